// File: rtl/norm_mult_scheduler.sv
// norm_mult_scheduler
//   Arbitrates two requesters (normalize / denormalize paths) onto one shared
//   32x32 multiplier. Each accepted operand is multiplied by a per-requester
//   constant (K0 or K1). The 64-bit product is reformatted into a 1:8:23 word
//   and returned on a valid/ready response channel. A WAIT timeout aborts a
//   stalled multiply with rsp_err set. Only one transaction is in flight.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   r0_valid/ready/a    requester 0 operand handshake
//   r1_valid/ready/a    requester 1 operand handshake
//   rsp_valid/ready     response handshake
//   rsp_id/y/err        response owner, formatted result, timeout flag
//   mult_start/a/b      start pulse and operands to the shared multiplier
//   mult_done/p         product-valid pulse and 64-bit product
module norm_mult_scheduler #(
   parameter logic [31:0] K0      = 32'h04000000,
   parameter logic [31:0] K1      = 32'h04000000,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic [31:0] r0_a,
   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic [31:0] r1_a,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_y,
   output logic        rsp_err,
   output logic        mult_start,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   input  logic        mult_done,
   input  logic [63:0] mult_p
);

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e      state_q;
   logic [7:0]  wait_cnt_q;
   logic        last_gnt_q;
   // Low while in reset and for the first cycle after release, so ready is
   // never shown (and nothing accepted) while reset is asserted.
   logic        run_q;

   logic        gnt0, gnt1, idle_en, accept;
   logic [7:0]  wait_cnt_inc;
   logic        timeout_hit;
   logic [31:0] y_fmt;
   logic        unused_p_bits;

   // Round-robin: on a tie the requester not granted last wins.
   assign gnt0 = r0_valid & (~r1_valid | last_gnt_q);
   assign gnt1 = r1_valid & (~r0_valid | ~last_gnt_q);

   assign idle_en  = (state_q == StIdle) & run_q;
   assign r0_ready = idle_en & gnt0;
   assign r1_ready = idle_en & gnt1;
   assign accept   = idle_en & (gnt0 | gnt1);

   assign wait_cnt_inc = wait_cnt_q + 8'd1;
   assign timeout_hit  = (wait_cnt_inc == TimeoutCnt);

   // Sign from bit 57, 5-bit exponent field from [56:52], 23-bit mantissa.
   assign y_fmt         = {mult_p[57], 3'b000, mult_p[56:52], mult_p[51:29]};
   assign unused_p_bits = ^{mult_p[63:58], mult_p[28:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         wait_cnt_q <= 8'd0;
         last_gnt_q <= 1'b1;
         run_q      <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_y      <= 32'd0;
         rsp_err    <= 1'b0;
         mult_start <= 1'b0;
         mult_a     <= 32'd0;
         mult_b     <= 32'd0;
      end else begin
         run_q <= 1'b1;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  mult_a     <= gnt1 ? r1_a : r0_a;
                  mult_b     <= gnt1 ? K1 : K0;
                  rsp_id     <= gnt1;
                  last_gnt_q <= gnt1;
                  mult_start <= 1'b1;
                  state_q    <= StIssue;
               end
            end
            StIssue: begin
               mult_start <= 1'b0;
               wait_cnt_q <= 8'd0;
               state_q    <= StWait;
            end
            StWait: begin
               // A product arriving on the timeout cycle still wins.
               if (mult_done) begin
                  rsp_y     <= y_fmt;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state_q   <= StResp;
               end else if (timeout_hit) begin
                  rsp_y     <= 32'd0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state_q   <= StResp;
               end else begin
                  wait_cnt_q <= wait_cnt_inc;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_norm_mult_scheduler.sv
// tb_norm_mult_scheduler
//   Directed + randomized bench for norm_mult_scheduler. The bench plays the
//   shared multiplier (product = a*b, done after a chosen number of WAIT
//   cycles), models round-robin grant order and the 1:8:23 result format
//   arithmetically, and checks every handshake cycle.
module tb_norm_mult_scheduler;

   localparam logic [31:0] K0P = 32'h04000000;
   localparam logic [31:0] K1P = 32'h03000001;
   localparam int          TO  = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r0_ready, r1_valid, r1_ready;
   logic [31:0] r0_a, r1_a;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [31:0] rsp_y;
   logic        mult_start, mult_done;
   logic [31:0] mult_a, mult_b;
   logic [63:0] mult_p;

   int          checks = 0;
   int          errors = 0;
   logic        last_m;
   logic        cur_id;
   logic [31:0] cur_a, cur_b;
   int          waited;

   norm_mult_scheduler #(
      .K0      (K0P),
      .K1      (K1P),
      .TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .r0_valid   (r0_valid),
      .r0_ready   (r0_ready),
      .r0_a       (r0_a),
      .r1_valid   (r1_valid),
      .r1_ready   (r1_ready),
      .r1_a       (r1_a),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_y      (rsp_y),
      .rsp_err    (rsp_err),
      .mult_start (mult_start),
      .mult_a     (mult_a),
      .mult_b     (mult_b),
      .mult_done  (mult_done),
      .mult_p     (mult_p)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Result format from plain arithmetic on the product.
   function automatic logic [31:0] fmt(input logic [63:0] p);
      logic [63:0] s, e, m;
      s = (p >> 57) % 64'd2;
      e = (p >> 52) % 64'd32;
      m = (p >> 29) % (64'd1 << 23);
      return 32'((s << 31) + (e << 23) + m);
   endfunction

   function automatic logic [127:0] all_outs();
      return 128'({r0_ready, r1_ready, rsp_valid, rsp_id, rsp_y, rsp_err,
                   mult_start, mult_a, mult_b});
   endfunction

   // Called at a negedge with valids driven; returns in the accept cycle.
   task automatic accept(output int w);
      logic eid;
      eid = (r0_valid && r1_valid) ? ~last_m : r1_valid;
      w = -1;
      for (int c = 0; c < 8 && w < 0; c++) begin
         #1;
         if (r0_ready || r1_ready) w = c;
         else @(negedge clk);
      end
      chk("grant", 128'({r0_ready, r1_ready}), 128'(eid ? 2'b01 : 2'b10));
      last_m = eid;
      cur_id = eid;
      cur_a  = eid ? r1_a : r0_a;
      cur_b  = eid ? K1P : K0P;
   endtask

   // k: WAIT cycle (1-based) carrying mult_done; 0 or >TO means never.
   task automatic serve(input int k, input int hold);
      logic [63:0] p;
      logic [31:0] ey;
      logic        eerr;
      int          nwait;
      p = {32'd0, cur_a} * {32'd0, cur_b};
      if (k >= 1 && k <= TO) begin
         nwait = k; ey = fmt(p); eerr = 1'b0;
      end else begin
         nwait = TO; ey = 32'd0; eerr = 1'b1;
      end
      @(negedge clk);
      chk("issue", 128'({mult_start, r0_ready, r1_ready, rsp_valid, mult_a, mult_b}),
          128'({4'b1000, cur_a, cur_b}));
      for (int w = 1; w <= nwait; w++) begin
         @(negedge clk);
         chk("wait", 128'({mult_start, r0_ready, r1_ready, rsp_valid, mult_a, mult_b}),
             128'({4'b0000, cur_a, cur_b}));
         if (w == k) begin
            mult_done = 1'b1;
            mult_p    = p;
         end
      end
      @(negedge clk);
      mult_done = 1'b0;
      mult_p    = {$urandom, $urandom};
      chk("rsp", 128'({rsp_valid, rsp_id, rsp_err, rsp_y}), 128'({1'b1, cur_id, eerr, ey}));
      for (int h = 0; h < hold; h++) begin
         if (h == 0 && eerr) begin
            mult_done = 1'b1;
            mult_p    = p;
         end
         @(negedge clk);
         mult_done = 1'b0;
         chk("hold", 128'({rsp_valid, rsp_id, rsp_err, rsp_y, mult_start, r0_ready, r1_ready}),
             128'({1'b1, cur_id, eerr, ey, 3'b000}));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_drop", 128'(rsp_valid), 128'(0));
   endtask

   initial begin
      rst       = 1'b0;
      r0_valid  = 1'b1;
      r1_valid  = 1'b1;
      r0_a      = 32'h1234_5678;
      r1_a      = 32'h0abc_def0;
      rsp_ready = 1'b0;
      mult_done = 1'b0;
      mult_p    = 64'd0;
      last_m    = 1'b1;

      // Reset state, with both requesters pending.
      @(negedge clk);
      chk("reset_outs", all_outs(), 128'(0));
      @(negedge clk);
      rst = 1'b1;

      // Both valid held high: grants 0,1,0,1 back to back, K alternates.
      for (int i = 0; i < 4; i++) begin
         r0_a = 32'h0100_0000 + 32'(i);
         r1_a = 32'h0200_0000 + 32'(i);
         accept(waited);
         chk("rr_id", 128'(cur_id), 128'(i % 2));
         if (i > 0) chk("rr_gap", 128'(waited), 128'(0));
         serve(1, 0);
      end
      r1_valid = 1'b0;

      // Single request, done in first WAIT cycle: 3-cycle latency, 1.0 result.
      r0_a = 32'h2000_0000;
      accept(waited);
      chk("unit_fmt", 128'(fmt({32'd0, r0_a} * {32'd0, K0P})), 128'(32'h0400_0000));
      serve(1, 0);

      // Timeout with a late product during RESP, then a stray done in IDLE.
      r0_a = 32'h2222_3333;
      accept(waited);
      serve(0, 2);
      r0_valid  = 1'b0;
      mult_done = 1'b1;
      @(negedge clk);
      mult_done = 1'b0;
      chk("stray_done", 128'({rsp_valid, mult_start}), 128'(0));

      // Product on the very cycle the counter reaches the limit.
      r0_valid = 1'b1;
      r0_a     = 32'h3fff_ffff;
      accept(waited);
      serve(TO, 0);

      // Response back-pressure for 10 cycles with requests pending.
      r1_valid = 1'b1;
      r1_a     = 32'hdead_beef;
      accept(waited);
      serve(3, 10);

      // Randomized traffic.
      for (int i = 0; i < 16; i++) begin
         logic [1:0] v;
         v        = 2'($urandom_range(1, 3));
         r0_valid = v[0];
         r1_valid = v[1];
         r0_a     = $urandom;
         r1_a     = $urandom;
         accept(waited);
         serve(int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 2)));
      end

      // Reset during WAIT: outputs clear at once, later product is dropped.
      r0_valid = 1'b1;
      r1_valid = 1'b0;
      r0_a     = 32'h2000_0000;
      accept(waited);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_async", all_outs(), 128'(0));
      @(negedge clk);
      rst       = 1'b1;
      r0_valid  = 1'b0;
      mult_done = 1'b1;
      mult_p    = 64'h0080_0000_0000_0000;
      @(negedge clk);
      mult_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rst_drop", 128'({rsp_valid, mult_start}), 128'(0));
      end

      // Last-grant resets to 1: r0 wins the first tie.
      last_m   = 1'b1;
      r0_valid = 1'b1;
      r1_valid = 1'b1;
      accept(waited);
      chk("rst_tie", 128'(cur_id), 128'(0));
      serve(2, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
